// File: rtl/cache_control.sv
// Control FSM for the 2-way, 16-set write-back/write-allocate L1 cache.
// Optional perf counters (hit/miss/writeback) are enabled by defining CACHE_PERF_CNT_EN.
module cache_control
`ifdef CACHE_PERF_CNT_EN
#(
    parameter int CNT_WIDTH = 16
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic mem_read,
    input  logic mem_write,
    output logic mem_resp,
    input  logic tag_hit,
    input  logic valid,
    input  logic dirty,
    output logic load_data,
    output logic load_valid,
    output logic load_dirty,
    output logic clear_dirty,
    output logic load_lru,
    output logic load_tag,
    output logic cache_in_sel,
    output logic pmem_addr_sel,
    output logic pmem_read,
    output logic pmem_write,
    input  logic pmem_resp
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       req;
    logic       hit;

    assign req = mem_read | mem_write;
    assign hit = tag_hit & valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst_n so nothing reaches the datapath while reset is held.
    always_comb begin
        state_d       = state_q;
        mem_resp      = 1'b0;
        load_data     = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        clear_dirty   = 1'b0;
        load_lru      = 1'b0;
        load_tag      = 1'b0;
        cache_in_sel  = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            load_lru = 1'b1;
                            if (mem_write) begin
                                load_data    = 1'b1;
                                cache_in_sel = 1'b1;
                                load_dirty   = 1'b1;
                            end
                        end else if (valid & dirty) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data   = 1'b1;
                        load_tag    = 1'b1;
                        load_valid  = 1'b1;
                        load_dirty  = 1'b1;
                        clear_dirty = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // miss_pending marks a request that already missed, so its final hit is not counted.
    logic miss_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count    <= '0;
            miss_count   <= '0;
            wb_count     <= '0;
            miss_pending <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d != IDLE) begin
                miss_pending <= 1'b1;
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end else if (state_q == IDLE && (mem_resp || !req)) begin
                miss_pending <= 1'b0;
            end
            if (mem_resp && !miss_pending && hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            if (state_q == WRITEBACK && pmem_resp && wb_count != '1) begin
                wb_count <= wb_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: each stimulus cycle queues its expected output vector,
// and a negedge monitor pops and compares it against the DUT.
module tb_cache_control;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read, mem_write, tag_hit, valid, dirty, pmem_resp;
    logic mem_resp, load_data, load_valid, load_dirty, clear_dirty, load_lru, load_tag;
    logic cache_in_sel, pmem_addr_sel, pmem_read, pmem_write;
`ifdef CACHE_PERF_CNT_EN
    logic [1:0] hit_count, miss_count, wb_count;
`endif

    always #5 clk = ~clk;

`ifdef CACHE_PERF_CNT_EN
    cache_control #(.CNT_WIDTH(2)) dut (
`else
    cache_control dut (
`endif
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .tag_hit(tag_hit), .valid(valid), .dirty(dirty),
        .load_data(load_data), .load_valid(load_valid), .load_dirty(load_dirty),
        .clear_dirty(clear_dirty), .load_lru(load_lru), .load_tag(load_tag),
        .cache_in_sel(cache_in_sel), .pmem_addr_sel(pmem_addr_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    // Output vector bits: mem_resp, load_data, load_valid, load_dirty, clear_dirty,
    // load_lru, load_tag, cache_in_sel, pmem_addr_sel, pmem_read, pmem_write
    localparam logic [10:0] B_RESP = 11'b10000000000;
    localparam logic [10:0] B_LD   = 11'b01000000000;
    localparam logic [10:0] B_LV   = 11'b00100000000;
    localparam logic [10:0] B_LDIR = 11'b00010000000;
    localparam logic [10:0] B_CD   = 11'b00001000000;
    localparam logic [10:0] B_LRU  = 11'b00000100000;
    localparam logic [10:0] B_TAG  = 11'b00000010000;
    localparam logic [10:0] B_SEL  = 11'b00000001000;
    localparam logic [10:0] B_ASEL = 11'b00000000100;
    localparam logic [10:0] B_PR   = 11'b00000000010;
    localparam logic [10:0] B_PW   = 11'b00000000001;

    localparam logic [10:0] NONE   = 11'b0;
    localparam logic [10:0] RD_HIT = B_RESP | B_LRU;
    localparam logic [10:0] WR_HIT = B_RESP | B_LRU | B_LD | B_SEL | B_LDIR;
    localparam logic [10:0] PREAD  = B_PR;
    localparam logic [10:0] FILL   = B_PR | B_LD | B_TAG | B_LV | B_LDIR | B_CD;
    localparam logic [10:0] PWRITE = B_PW | B_ASEL;

    // Input vector: mem_read, mem_write, tag_hit, valid, dirty, pmem_resp
    localparam logic [5:0] I_NONE    = 6'b000000;
    localparam logic [5:0] I_RD_HIT  = 6'b101100;
    localparam logic [5:0] I_WR_HIT  = 6'b011100;
    localparam logic [5:0] I_RW_HIT  = 6'b111100;
    localparam logic [5:0] I_RD_MISS = 6'b100000;
    localparam logic [5:0] I_RD_RESP = 6'b100001;
    localparam logic [5:0] I_WR_DMIS = 6'b010110;
    localparam logic [5:0] I_WR_DRSP = 6'b010111;
    localparam logic [5:0] I_RESP    = 6'b000001;
    localparam logic [5:0] I_INV_DRT = 6'b100010;
    localparam logic [5:0] I_TAG_INV = 6'b101000;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int unsigned n_compared = 0;
    int unsigned n_failed   = 0;

    wire [10:0] out_v = {mem_resp, load_data, load_valid, load_dirty, clear_dirty,
                         load_lru, load_tag, cache_in_sel, pmem_addr_sel, pmem_read, pmem_write};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_compared++;
            if (out_v !== e) begin
                n_failed++;
                $display("FAIL %s: outputs got %b expected %b", nm, out_v, e);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] in, input logic [10:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n = r;
        {mem_read, mem_write, tag_hit, valid, dirty, pmem_resp} = in;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {mem_read, mem_write, tag_hit, valid, dirty, pmem_resp} = I_NONE;

        step(1'b0, I_RD_HIT,  NONE,   "reset_gated");
        step(1'b0, I_RD_HIT,  NONE,   "reset_gated2");
        step(1'b1, I_RD_HIT,  RD_HIT, "rd_hit");
        step(1'b1, I_NONE,    NONE,   "idle");
        step(1'b1, I_WR_HIT,  WR_HIT, "wr_hit");
        step(1'b1, I_RW_HIT,  WR_HIT, "rw_as_write");
        step(1'b1, I_RD_HIT,  RD_HIT, "rd_hit4");
        step(1'b1, I_RD_HIT,  RD_HIT, "rd_hit5");

        step(1'b1, I_WR_DMIS, NONE,   "dmiss_req");
        step(1'b1, I_WR_DMIS, PWRITE, "dmiss_wb_wait");
        step(1'b1, I_WR_DRSP, PWRITE, "dmiss_wb_resp");
        step(1'b1, I_WR_DMIS, PREAD,  "dmiss_fill_wait");
        step(1'b1, I_WR_DRSP, FILL,   "dmiss_fill");
        step(1'b1, I_WR_HIT,  WR_HIT, "dmiss_hit");
        step(1'b1, I_NONE,    NONE,   "dmiss_idle");

`ifdef CACHE_PERF_CNT_EN
        n_compared++;
        if (hit_count !== 2'd3) begin
            n_failed++;
            $display("FAIL hit_count_sat: got %0d expected 3", hit_count);
        end
        n_compared++;
        if (miss_count !== 2'd1) begin
            n_failed++;
            $display("FAIL miss_count: got %0d expected 1", miss_count);
        end
        n_compared++;
        if (wb_count !== 2'd1) begin
            n_failed++;
            $display("FAIL wb_count: got %0d expected 1", wb_count);
        end
`endif

        step(1'b1, I_RD_MISS, NONE,   "cmiss_req");
        step(1'b1, I_RD_MISS, PREAD,  "cmiss_wait1");
        step(1'b1, I_RD_MISS, PREAD,  "cmiss_wait2");
        step(1'b1, I_RD_MISS, PREAD,  "cmiss_wait3");
        step(1'b1, I_RD_RESP, FILL,   "cmiss_fill");
        step(1'b1, I_RD_HIT,  RD_HIT, "cmiss_hit");

        step(1'b1, I_INV_DRT, NONE,   "inv_dirty_req");
        step(1'b1, I_INV_DRT, PREAD,  "inv_dirty_no_wb");
        step(1'b1, I_RD_RESP, FILL,   "inv_dirty_fill");
        step(1'b1, I_TAG_INV, NONE,   "taghit_invalid_req");
        step(1'b1, I_TAG_INV, PREAD,  "taghit_invalid_alloc");

        step(1'b1, I_RESP,    FILL,   "drop_fill");
        step(1'b1, I_NONE,    NONE,   "drop_no_resp");
        step(1'b1, I_NONE,    NONE,   "drop_idle");

        step(1'b1, I_RD_MISS, NONE,   "rst_mid_req");
        step(1'b1, I_RD_MISS, PREAD,  "rst_mid_alloc");
        step(1'b0, I_RD_MISS, NONE,   "rst_mid_drop");
        step(1'b1, I_NONE,    NONE,   "rst_release");
        step(1'b1, I_NONE,    NONE,   "rst_release_idle");
        step(1'b1, I_RD_HIT,  RD_HIT, "post_rst_hit");

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
